// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser: one pixel word per cycle, first push two cycles after start, done after the last pixel.
// Backpressure: fifofull freezes the walk and masks push; off-screen pixels consume a step without a push.
module line_draw_engine #(
  parameter int HPOS_WIDTH   = 10,
  parameter int VPOS_WIDTH   = 10,
  parameter int RESOLUTION_H = 640,
  parameter int RESOLUTION_V = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [HPOS_WIDTH-1:0] x0,
  input  logic [HPOS_WIDTH-1:0] x1,
  input  logic [VPOS_WIDTH-1:0] y0,
  input  logic [VPOS_WIDTH-1:0] y1,
  input  logic [2:0]            color,
  input  logic                  fifofull,
  output logic                  push,
  output logic [HPOS_WIDTH-1:0] hpos,
  output logic [VPOS_WIDTH-1:0] vpos,
  output logic [2:0]            RGB,
  output logic                  busy,
  output logic                  done
);

  localparam int W = ((HPOS_WIDTH > VPOS_WIDTH) ? HPOS_WIDTH : VPOS_WIDTH) + 2;
  localparam logic [HPOS_WIDTH:0] RES_H = (HPOS_WIDTH+1)'(RESOLUTION_H);
  localparam logic [VPOS_WIDTH:0] RES_V = (VPOS_WIDTH+1)'(RESOLUTION_V);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [HPOS_WIDTH-1:0] x0_r, x1_r, cx;
  logic [VPOS_WIDTH-1:0] y0_r, y1_r, cy;
  logic [2:0]            color_r;
  logic signed [W-1:0]   dx, dy, err;
  logic                  sx_neg, sy_neg;

  logic [HPOS_WIDTH-1:0] adx;
  logic [VPOS_WIDTH-1:0] ady;
  logic signed [W-1:0]   dx_init, dy_init, err_nxt;
  logic signed [W:0]     e2, dx_ext, dy_ext;
  logic                  step_x, step_y, at_end, visible, advance;

  assign adx     = (x1_r >= x0_r) ? (x1_r - x0_r) : (x0_r - x1_r);
  assign ady     = (y1_r >= y0_r) ? (y1_r - y0_r) : (y0_r - y1_r);
  assign dx_init = $signed(W'(adx));
  assign dy_init = -$signed(W'(ady));

  // e2 is 2*err; one extra bit keeps the doubled value exact.
  assign e2      = $signed({err, 1'b0});
  assign dx_ext  = $signed({dx[W-1], dx});
  assign dy_ext  = $signed({dy[W-1], dy});
  assign step_x  = (e2 >= dy_ext);
  assign step_y  = (e2 <= dx_ext);
  assign at_end  = (cx == x1_r) && (cy == y1_r);
  assign visible = ({1'b0, cx} < RES_H) && ({1'b0, cy} < RES_V);
  assign advance = (state == S_RUN) && !fifofull && !at_end;

  always_comb begin
    err_nxt = err;
    if (step_x) err_nxt = err_nxt + dy;
    if (step_y) err_nxt = err_nxt + dx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_INIT;
      S_INIT: state_nxt = S_RUN;
      S_RUN:  if (!fifofull && at_end) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    push = (state == S_RUN) && !fifofull && visible;
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_r    <= '0;
      x1_r    <= '0;
      y0_r    <= '0;
      y1_r    <= '0;
      color_r <= '0;
      cx      <= '0;
      cy      <= '0;
      dx      <= '0;
      dy      <= '0;
      err     <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x0_r    <= x0;
            x1_r    <= x1;
            y0_r    <= y0;
            y1_r    <= y1;
            color_r <= color;
          end
        end
        S_INIT: begin
          dx     <= dx_init;
          dy     <= dy_init;
          err    <= dx_init + dy_init;
          sx_neg <= !(x0_r < x1_r);
          sy_neg <= !(y0_r < y1_r);
          cx     <= x0_r;
          cy     <= y0_r;
        end
        S_RUN: begin
          if (advance) begin
            err <= err_nxt;
            if (step_x) cx <= sx_neg ? (cx - HPOS_WIDTH'(1)) : (cx + HPOS_WIDTH'(1));
            if (step_y) cy <= sy_neg ? (cy - VPOS_WIDTH'(1)) : (cy + VPOS_WIDTH'(1));
          end
        end
        default: ;
      endcase
    end
  end

  assign hpos = cx;
  assign vpos = cy;
  assign RGB  = color_r;

endmodule
